bias_activation_pipe: RTL and testbench

Multi-lane, pipelined bias-add and activation stage between the systolic array accumulator drain and the next layer's activation buffer. Each accepted beat carries LANES wide accumulator values plus per-lane biases. Each lane is bias-added, requantised to DATA_WIDTH with saturation, then passed through ReLU, sigmoid, tanh or identity. Flow control is valid/ready on both sides, and the block keeps a saturation event counter.

---
 rtl/bias_activation_pipe_if.sv | 28 ++
 rtl/bias_activation_pipe.sv | 176 +++++++++++++++++
 tb/tb_bias_activation_pipe.sv | 264 ++++++++++++++++++++++++++
 3 files changed

// File: rtl/bias_activation_pipe_if.sv
// rtl/bias_activation_pipe_if.sv - beat handshake, data and saturation-counter signals of bias_activation_pipe
interface bias_activation_pipe_if #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32
);
  logic                          in_valid_i;
  logic                          in_ready_o;
  logic [1:0]                    activ_type_i;
  logic [LANES*ACC_WIDTH-1:0]    acc_i;
  logic [LANES*DATA_WIDTH-1:0]   bias_i;
  logic                          out_valid_o;
  logic                          out_ready_i;
  logic [LANES*DATA_WIDTH-1:0]   y_o;
  logic                          sat_o;
  logic                          sat_clr_i;
  logic [15:0]                   sat_count_o;

  modport master (
    output in_valid_i, activ_type_i, acc_i, bias_i, out_ready_i, sat_clr_i,
    input  in_ready_o, out_valid_o, y_o, sat_o, sat_count_o
  );

  modport slave (
    input  in_valid_i, activ_type_i, acc_i, bias_i, out_ready_i, sat_clr_i,
    output in_ready_o, out_valid_o, y_o, sat_o, sat_count_o
  );
endinterface

// File: rtl/bias_activation_pipe.sv
// rtl/bias_activation_pipe.sv - multi-lane bias-add, saturating requantise and activation pipeline
// LEAKY_RELU_EN: when defined, mode 0 is leaky ReLU (slope 1/8) instead of plain ReLU
module bias_activation_pipe #(
  parameter int LANES      = 4,
  parameter int DATA_WIDTH = 16,
  parameter int ACC_WIDTH  = 32,
  parameter int FRAC_BITS  = 8,
  parameter int ACC_FRAC   = 16
) (
  input  logic                 clk_i,
  input  logic                 rst_i,
  bias_activation_pipe_if.slave bus
);

  localparam int SHIFT = ACC_FRAC - FRAC_BITS;

  localparam logic signed [ACC_WIDTH:0] QMAX = {{(ACC_WIDTH-DATA_WIDTH+2){1'b0}}, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [ACC_WIDTH:0] QMIN = {{(ACC_WIDTH-DATA_WIDTH+2){1'b1}}, {(DATA_WIDTH-1){1'b0}}};
  localparam logic signed [DATA_WIDTH-1:0] SMAX = {1'b0, {(DATA_WIDTH-1){1'b1}}};
  localparam logic signed [DATA_WIDTH-1:0] SMIN = {1'b1, {(DATA_WIDTH-1){1'b0}}};

  // Sigmoid breakpoints and offsets, floor-quantised to the output Q format
  localparam logic [DATA_WIDTH-1:0] ONE   = DATA_WIDTH'(1 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] A_SAT = DATA_WIDTH'(5 << FRAC_BITS);
  localparam logic [DATA_WIDTH-1:0] A_MID = DATA_WIDTH'((19 << FRAC_BITS) >> 3);
  localparam logic [DATA_WIDTH-1:0] C_HI  = DATA_WIDTH'((27 << FRAC_BITS) >> 5);
  localparam logic [DATA_WIDTH-1:0] C_MID = DATA_WIDTH'((5 << FRAC_BITS) >> 3);
  localparam logic [DATA_WIDTH-1:0] C_LO  = DATA_WIDTH'(1 << (FRAC_BITS - 1));

  function automatic logic [DATA_WIDTH:0] requant(input logic signed [ACC_WIDTH-1:0]  acc,
                                                  input logic signed [DATA_WIDTH-1:0] bias);
    logic signed [ACC_WIDTH:0] sum;
    logic signed [ACC_WIDTH:0] q;
    sum = $signed({acc[ACC_WIDTH-1], acc})
        + ($signed({{(ACC_WIDTH+1-DATA_WIDTH){bias[DATA_WIDTH-1]}}, bias}) <<< SHIFT);
    q = sum >>> SHIFT;
    if (q > QMAX)
      requant = {1'b1, SMAX};
    else if (q < QMIN)
      requant = {1'b1, SMIN};
    else
      requant = {1'b0, q[DATA_WIDTH-1:0]};
  endfunction

  // |SMIN| comes out as 2^(DATA_WIDTH-1) unsigned, which lands in the saturated segment
  function automatic logic [DATA_WIDTH-1:0] sigmoid(input logic signed [DATA_WIDTH-1:0] x);
    logic [DATA_WIDTH-1:0] a;
    logic [DATA_WIDTH-1:0] f;
    a = x[DATA_WIDTH-1] ? (~x + 1'b1) : x;
    if (a >= A_SAT)
      f = ONE;
    else if (a >= A_MID)
      f = (a >> 5) + C_HI;
    else if (a >= ONE)
      f = (a >> 3) + C_MID;
    else
      f = (a >> 2) + C_LO;
    sigmoid = x[DATA_WIDTH-1] ? (ONE - f) : f;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] tanh_f(input logic signed [DATA_WIDTH-1:0] x);
    logic signed [DATA_WIDTH-1:0] x2;
    logic [DATA_WIDTH-1:0]        s;
    if (x[DATA_WIDTH-1] != x[DATA_WIDTH-2])
      x2 = x[DATA_WIDTH-1] ? SMIN : SMAX;
    else
      x2 = {x[DATA_WIDTH-2:0], 1'b0};
    s = sigmoid(x2);
    tanh_f = (s << 1) - ONE;
  endfunction

  function automatic logic [DATA_WIDTH-1:0] activate(input logic [1:0] mode,
                                                     input logic signed [DATA_WIDTH-1:0] x);
    case (mode)
`ifdef LEAKY_RELU_EN
      2'd0:    activate = x[DATA_WIDTH-1] ? (x >>> 3) : x;
`else
      2'd0:    activate = x[DATA_WIDTH-1] ? '0 : x;
`endif
      2'd1:    activate = sigmoid(x);
      2'd2:    activate = tanh_f(x);
      default: activate = x;
    endcase
  endfunction

  logic                        s0_valid, s1_valid, s2_valid, s3_valid;
  logic                        en0, en1, en2, en3;
  logic [1:0]                  s0_mode, s1_mode;
  logic [LANES*ACC_WIDTH-1:0]  s0_acc;
  logic [LANES*DATA_WIDTH-1:0] s0_bias;
  logic [LANES*DATA_WIDTH-1:0] s1_x, s2_y, s3_y;
  logic [LANES-1:0]            s1_sat;
  logic                        s2_sat, s3_sat;
  logic [LANES*DATA_WIDTH-1:0] q_c, y_c;
  logic [LANES-1:0]            sat_c;
  logic [15:0]                 sat_count;

  // A stage may load when it is empty or its contents move on this edge
  assign en3 = !s3_valid || bus.out_ready_i;
  assign en2 = !s2_valid || en3;
  assign en1 = !s1_valid || en2;
  assign en0 = !s0_valid || en1;

  assign bus.in_ready_o  = en0;
  assign bus.out_valid_o = s3_valid;
  assign bus.y_o         = s3_y;
  assign bus.sat_o       = s3_sat;
  assign bus.sat_count_o = sat_count;

  always_comb begin
    q_c   = '0;
    sat_c = '0;
    y_c   = '0;
    for (int l = 0; l < LANES; l++) begin
      {sat_c[l], q_c[l*DATA_WIDTH +: DATA_WIDTH]} =
        requant(s0_acc[l*ACC_WIDTH +: ACC_WIDTH], s0_bias[l*DATA_WIDTH +: DATA_WIDTH]);
      y_c[l*DATA_WIDTH +: DATA_WIDTH] = activate(s1_mode, s1_x[l*DATA_WIDTH +: DATA_WIDTH]);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_valid <= 1'b0;
      s1_valid <= 1'b0;
      s2_valid <= 1'b0;
      s3_valid <= 1'b0;
    end else begin
      if (en0) s0_valid <= bus.in_valid_i;
      if (en1) s1_valid <= s0_valid;
      if (en2) s2_valid <= s1_valid;
      if (en3) s3_valid <= s2_valid;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      s0_mode <= '0;
      s0_acc  <= '0;
      s0_bias <= '0;
      s1_mode <= '0;
      s1_x    <= '0;
      s1_sat  <= '0;
      s2_y    <= '0;
      s2_sat  <= 1'b0;
      s3_y    <= '0;
      s3_sat  <= 1'b0;
    end else begin
      if (en0 && bus.in_valid_i) begin
        s0_mode <= bus.activ_type_i;
        s0_acc  <= bus.acc_i;
        s0_bias <= bus.bias_i;
      end
      if (en1 && s0_valid) begin
        s1_mode <= s0_mode;
        s1_x    <= q_c;
        s1_sat  <= sat_c;
      end
      if (en2 && s1_valid) begin
        s2_y   <= y_c;
        s2_sat <= |s1_sat;
      end
      if (en3 && s2_valid) begin
        s3_y   <= s2_y;
        s3_sat <= s2_sat;
      end
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i || bus.sat_clr_i)
      sat_count <= '0;
    else if (s3_valid && bus.out_ready_i && s3_sat && (sat_count != 16'hFFFF))
      sat_count <= sat_count + 16'd1;
  end

endmodule

// File: tb/tb_bias_activation_pipe.sv
// tb/tb_bias_activation_pipe.sv - directed-vector bench for bias_activation_pipe
module tb_bias_activation_pipe;

  localparam int LANES = 4;
  localparam int DW    = 16;
  localparam int AW    = 32;

  logic clk;
  logic rst;

  bias_activation_pipe_if #(.LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW)) bus ();

  bias_activation_pipe #(
    .LANES(LANES), .DATA_WIDTH(DW), .ACC_WIDTH(AW), .FRAC_BITS(8), .ACC_FRAC(16)
  ) dut (
    .clk_i (clk),
    .rst_i (rst),
    .bus   (bus)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  int checks = 0;
  int errors = 0;

  logic [127:0] vacc  [10];
  logic [63:0]  vbias [10];
  logic [1:0]   vmode [10];
  logic [63:0]  vy    [10];
  logic         vsat  [10];

  int          exp_idx [$];
  logic [63:0] got_y   [$];
  logic        got_sat [$];

  logic        rand_en = 1'b0;
  logic        prev_stall = 1'b0;
  logic [65:0] prev_out = '0;

  task automatic check(input string tag, input logic [63:0] got, input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
    end
  endtask

  always @(posedge clk) begin
    #2;
    if (rand_en) bus.out_ready_i = 1'($urandom_range(0, 1));
  end

  always @(negedge clk) begin
    #3;
    if (rst) begin
      prev_stall = 1'b0;
    end else begin
      if (prev_stall)
        check("stall_hold", {bus.out_valid_o, bus.sat_o, bus.y_o}, prev_out);
      if (bus.out_valid_o && bus.out_ready_i) begin
        got_y.push_back(bus.y_o);
        got_sat.push_back(bus.sat_o);
      end
      prev_stall = bus.out_valid_o && !bus.out_ready_i;
      prev_out   = {bus.out_valid_o, bus.sat_o, bus.y_o};
    end
  end

  task automatic send(input int idx);
    int   n  = 0;
    logic ok = 1'b0;
    bus.in_valid_i   = 1'b1;
    bus.acc_i        = vacc[idx];
    bus.bias_i       = vbias[idx];
    bus.activ_type_i = vmode[idx];
    while (!ok && n < 200) begin
      #4;
      ok = bus.in_ready_o;
      @(negedge clk);
      n++;
    end
    bus.in_valid_i = 1'b0;
    check($sformatf("accept_v%0d", idx), ok, 1);
    if (ok) exp_idx.push_back(idx);
  endtask

  task automatic drain(input int n);
    int budget = 0;
    while (got_y.size() < n && budget < 300) begin
      @(negedge clk);
      budget++;
    end
    repeat (2) @(negedge clk);
  endtask

  task automatic compare_outputs(input string phase);
    check({phase, "_count"}, got_y.size(), exp_idx.size());
    while (got_y.size() > 0 && exp_idx.size() > 0) begin
      int idx;
      idx = exp_idx.pop_front();
      check($sformatf("%s_y_v%0d", phase, idx), got_y.pop_front(), vy[idx]);
      check($sformatf("%s_sat_v%0d", phase, idx), got_sat.pop_front(), vsat[idx]);
    end
    got_y.delete();
    got_sat.delete();
    exp_idx.delete();
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not complete");
    $fatal(1);
  end

  initial begin
    int cnt;

    // ReLU / leaky: 1.5+1.0, -2.0, 1.0-1.0, -1/512 (floors to -1 LSB)
    vacc[0]  = {32'hFFFFFF80, 32'h00010000, 32'hFFFE0000, 32'h00018000};
    vbias[0] = {16'h0000, 16'hFF00, 16'h0000, 16'h0100};
    vmode[0] = 2'd0;
`ifdef LEAKY_RELU_EN
    vy[0]    = {16'hFFFF, 16'h0000, 16'hFFC0, 16'h0280};
`else
    vy[0]    = {16'h0000, 16'h0000, 16'h0000, 16'h0280};
`endif
    vsat[0]  = 1'b0;
    // Sigmoid: 0, 1.0, -1.0, 6.0
    vacc[1]  = {32'h00060000, 32'hFFFF0000, 32'h00010000, 32'h00000000};
    vbias[1] = '0;
    vmode[1] = 2'd1;
    vy[1]    = {16'h0100, 16'h0040, 16'h00C0, 16'h0080};
    vsat[1]  = 1'b0;
    // Sigmoid: 2.5, -2.5, 0.5, most-negative (requant saturates)
    vacc[2]  = {32'h80000000, 32'h00008000, 32'hFFFD8000, 32'h00028000};
    vbias[2] = '0;
    vmode[2] = 2'd1;
    vy[2]    = {16'h0000, 16'h00A0, 16'h0014, 16'h00EC};
    vsat[2]  = 1'b1;
    // tanh: 0, 1.0, -1.0, 64.0 (doubling saturates)
    vacc[3]  = {32'h00400000, 32'hFFFF0000, 32'h00010000, 32'h00000000};
    vbias[3] = '0;
    vmode[3] = 2'd2;
    vy[3]    = {16'h0100, 16'hFF40, 16'h00C0, 16'h0000};
    vsat[3]  = 1'b0;
    // Identity with positive and negative clamp
    vacc[4]  = {32'hFFFFFF00, 32'h00123456, 32'h80000000, 32'h7FFF0000};
    vbias[4] = {16'hFFFF, 16'h0010, 16'h8000, 16'h7FFF};
    vmode[4] = 2'd3;
    vy[4]    = {16'hFFFE, 16'h1244, 16'h8000, 16'h7FFF};
    vsat[4]  = 1'b1;
    // Identity exactly at the range limits, no saturation
    vacc[5]  = {32'h00000100, 32'h00000000, 32'hFF800000, 32'h007FFF00};
    vbias[5] = '0;
    vmode[5] = 2'd3;
    vy[5]    = {16'h0001, 16'h0000, 16'h8000, 16'h7FFF};
    vsat[5]  = 1'b0;
    // Same data (1.0, -1.0, 2.5, 0) through each mode
    for (int i = 6; i < 10; i++) begin
      vacc[i]  = {32'h00000000, 32'h00028000, 32'hFFFF0000, 32'h00010000};
      vbias[i] = '0;
      vmode[i] = 2'(i - 6);
      vsat[i]  = 1'b0;
    end
`ifdef LEAKY_RELU_EN
    vy[6] = {16'h0000, 16'h0280, 16'hFFE0, 16'h0100};
`else
    vy[6] = {16'h0000, 16'h0280, 16'h0000, 16'h0100};
`endif
    vy[7] = {16'h0080, 16'h00EC, 16'h0040, 16'h00C0};
    vy[8] = {16'h0000, 16'h0100, 16'hFF40, 16'h00C0};
    vy[9] = {16'h0000, 16'h0280, 16'hFF00, 16'h0100};

    rst              = 1'b1;
    bus.in_valid_i   = 1'b0;
    bus.activ_type_i = '0;
    bus.acc_i        = '0;
    bus.bias_i       = '0;
    bus.out_ready_i  = 1'b1;
    bus.sat_clr_i    = 1'b0;
    repeat (3) @(negedge clk);
    check("rst_out_valid", bus.out_valid_o, 0);
    check("rst_y", bus.y_o, 0);
    check("rst_sat", bus.sat_o, 0);
    check("rst_sat_count", bus.sat_count_o, 0);
    rst = 1'b0;
    @(negedge clk);
    check("rst_in_ready", bus.in_ready_o, 1);

    send(0);
    check("lat_idle", bus.out_valid_o, 0);
    cnt = 0;
    while (!bus.out_valid_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    check("latency", cnt, 3);
    drain(1);
    compare_outputs("a");
    check("sat_count_a", bus.sat_count_o, 0);

    for (int i = 1; i <= 5; i++) send(i);
    drain(5);
    compare_outputs("b");
    check("sat_count_b", bus.sat_count_o, 2);

    send(4);
    cnt = 0;
    while (!bus.out_valid_o && cnt < 10) begin
      @(negedge clk);
      cnt++;
    end
    bus.sat_clr_i = 1'b1;
    @(negedge clk);
    bus.sat_clr_i = 1'b0;
    check("sat_clr_same_cycle", bus.sat_count_o, 0);
    drain(1);
    compare_outputs("c1");
    send(4);
    drain(1);
    compare_outputs("c2");
    check("sat_count_inc", bus.sat_count_o, 1);

    rand_en = 1'b1;
    for (int i = 0; i < 10; i++) begin
      send(i);
      repeat ($urandom_range(0, 2)) @(negedge clk);
    end
    drain(10);
    rand_en = 1'b0;
    @(negedge clk);
    bus.out_ready_i = 1'b1;
    compare_outputs("d");
    check("sat_count_d", bus.sat_count_o, 3);

    for (int i = 6; i < 10; i++) send(i);
    drain(4);
    compare_outputs("e");
    check("sat_count_e", bus.sat_count_o, 3);

    bus.out_ready_i = 1'b0;
    send(4);
    send(2);
    send(0);
    @(negedge clk);
    check("f_stalled_valid", bus.out_valid_o, 1);
    rst = 1'b1;
    @(negedge clk);
    check("f_rst_out_valid", bus.out_valid_o, 0);
    check("f_rst_sat_count", bus.sat_count_o, 0);
    rst = 1'b0;
    bus.out_ready_i = 1'b1;
    exp_idx.delete();
    check("f_in_ready", bus.in_ready_o, 1);
    repeat (10) @(negedge clk);
    check("f_no_stale", got_y.size(), 0);
    check("f_sat_count_after", bus.sat_count_o, 0);

    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
